// File: rtl/dg004x_pkg.sv
// rtl/dg004x_pkg.sv - shared command encoding and helpers for the DG004x stack blocks
package dg004x_pkg;

    localparam logic [1:0] CMD_HOLD = 2'b00;
    localparam logic [1:0] CMD_REPL = 2'b01;
    localparam logic [1:0] CMD_PUSH = 2'b10;
    localparam logic [1:0] CMD_POP  = 2'b11;

    // Next-value source for one stack entry; "above" is toward the top of stack.
    typedef enum logic [1:0] {
        SEL_HOLD  = 2'b00,
        SEL_ABOVE = 2'b01,
        SEL_BELOW = 2'b10,
        SEL_LOAD  = 2'b11
    } cell_sel_e;

    // Index width that stays at least one bit even for a single-entry range.
    function automatic int idx_width(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/dg0041_stack_cell.sv
// rtl/dg0041_stack_cell.sv - one stack entry register with hold/above/below/load mux
module dg0041_stack_cell
    import dg004x_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             STK_CLK,
    input  logic             STK_RST,
    input  cell_sel_e        sel,
    input  logic [WIDTH-1:0] above,
    input  logic [WIDTH-1:0] below,
    input  logic [WIDTH-1:0] load,
    output logic [WIDTH-1:0] q
);

    // Entry register: reset clears, otherwise take the selected neighbour or the load value.
    always_ff @(posedge STK_CLK) begin
        if (STK_RST) begin
            q <= '0;
        end else begin
            case (sel)
                SEL_ABOVE: q <= above;
                SEL_BELOW: q <= below;
                SEL_LOAD:  q <= load;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/dg0041_param_stack.sv
// rtl/dg0041_param_stack.sv - parametrised return-address stack with level, flags and peek
module dg0041_param_stack
    import dg004x_pkg::*;
#(
    parameter int WIDTH     = 10,
    parameter int DEPTH     = 4,
    parameter int FILL_ZERO = 0
) (
    input  logic                          STK_CLK,
    input  logic                          STK_RST,
    input  logic                          MODE1,
    input  logic                          MODE0,
    input  logic [WIDTH-1:0]              PC,
    input  logic                          CLR_FLAGS,
    input  logic [idx_width(DEPTH)-1:0]   RD_IDX,
    output logic [WIDTH-1:0]              TOS,
    output logic [WIDTH-1:0]              RD_DATA,
    output logic [$clog2(DEPTH+1)-1:0]    LEVEL,
    output logic                          FULL,
    output logic                          EMPTY,
    output logic                          OVF,
    output logic                          UNF
);

    localparam int IW = idx_width(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [LW-1:0] LEVEL_MAX = LW'(DEPTH);

    logic [1:0]       cmd;
    logic [WIDTH-1:0] e [DEPTH];
    cell_sel_e        sel_top;
    cell_sel_e        sel_rest;
    logic             ovf_event;
    logic             unf_event;

    assign cmd = {MODE1, MODE0};

    // Decode the command into the mux select for the top entry and for all deeper entries.
    always_comb begin
        sel_top  = SEL_HOLD;
        sel_rest = SEL_HOLD;
        case (cmd)
            CMD_REPL: sel_top = SEL_LOAD;
            CMD_PUSH: begin
                sel_top  = SEL_LOAD;
                sel_rest = SEL_ABOVE;
            end
            CMD_POP: begin
                sel_top  = SEL_BELOW;
                sel_rest = SEL_BELOW;
            end
            default: ;
        endcase
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        logic [WIDTH-1:0] above;
        logic [WIDTH-1:0] below;

        if (i == 0) begin : g_top
            assign above = '0;
        end else begin : g_mid_a
            assign above = e[i-1];
        end

        // The bottom entry refills from itself (legacy replicate) or with zero on pop.
        if (i == DEPTH - 1) begin : g_bot
            assign below = (FILL_ZERO != 0) ? '0 : e[i];
        end else begin : g_mid_b
            assign below = e[i+1];
        end

        dg0041_stack_cell #(.WIDTH(WIDTH)) u_cell (
            .STK_CLK (STK_CLK),
            .STK_RST (STK_RST),
            .sel     ((i == 0) ? sel_top : sel_rest),
            .above   (above),
            .below   (below),
            .load    (PC),
            .q       (e[i])
        );
    end

    assign ovf_event = (cmd == CMD_PUSH) && (LEVEL == LEVEL_MAX);
    assign unf_event = (cmd == CMD_POP) && (LEVEL == '0);

    // Occupancy count saturating at 0 and DEPTH; sticky flags where a set beats a clear.
    always_ff @(posedge STK_CLK) begin
        if (STK_RST) begin
            LEVEL <= '0;
            OVF   <= 1'b0;
            UNF   <= 1'b0;
        end else begin
            case (cmd)
                CMD_REPL: if (LEVEL == '0) LEVEL <= LW'(1);
                CMD_PUSH: if (LEVEL != LEVEL_MAX) LEVEL <= LEVEL + LW'(1);
                CMD_POP:  if (LEVEL != '0) LEVEL <= LEVEL - LW'(1);
                default:  ;
            endcase
            OVF <= (OVF & ~CLR_FLAGS) | ovf_event;
            UNF <= (UNF & ~CLR_FLAGS) | unf_event;
        end
    end

    // Peek mux; indices past the last entry read as zero.
    always_comb begin
        RD_DATA = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (RD_IDX == IW'(i)) RD_DATA = e[i];
        end
    end

    assign TOS   = e[0];
    assign FULL  = (LEVEL == LEVEL_MAX);
    assign EMPTY = (LEVEL == '0);

endmodule
